i2s_rx_fifo: RTL and testbench

Parameterised I2S master receiver, successor to the single-word mono capture block. Generates BCLK/WS from the system clock with a programmable divider and captures stereo samples of configurable width, MSB first with the standard one-bit I2S delay. Each sample is tagged with its channel and buffered in an internal FIFO. The FIFO is drained over a valid/ready interface toward the DMA/accelerator side of the SoC.

---
 rtl/i2s_rx_fifo.sv | 166 ++++++++++++++++
 tb/tb_i2s_rx_fifo.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_fifo.sv
// I2S master receiver: BCLK/WS generation, stereo sample capture with the
// one-bit I2S delay, channel tagging and a first-word fall-through FIFO.
module i2s_rx_fifo #(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned CLK_DIV    = 3,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  en,
    input  logic [1:0]                            mode,
    output logic                                  BCLK,
    output logic                                  WS,
    input  logic                                  DIN,
    output logic [DATA_W-1:0]                     rd_data,
    output logic                                  rd_ch,
    output logic                                  rd_valid,
    input  logic                                  rd_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_level,
    output logic                                  overrun,
    input  logic                                  clr_overrun
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W = $clog2(SLOT_W);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = $clog2(FIFO_DEPTH + 1);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic              bclk_q, bclk_d;
    logic              ws_q, ws_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              pend_q, pend_d;
    logic              pend_ch_q, pend_ch_d;

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
    logic              ch_mem_q   [FIFO_DEPTH];

    logic              tick_c;
    logic              ch_en_c;
    logic              push_c;
    logic              pop_c;
    logic              full_c;
    logic              wr_c;

    // Bit-clock divider, slot/bit tracking and serial capture
    always_comb begin
        cnt_d     = cnt_q;
        bclk_d    = bclk_q;
        ws_d      = ws_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        pend_d    = 1'b0;
        pend_ch_d = pend_ch_q;
        tick_c    = (cnt_q == DIV_W'(CLK_DIV - 1));
        if (!en) begin
            cnt_d   = '0;
            bclk_d  = 1'b0;
            ws_d    = 1'b0;
            bit_d   = '0;
            shift_d = '0;
        end else begin
            cnt_d = tick_c ? '0 : cnt_q + DIV_W'(1);
            if (tick_c) begin
                bclk_d = ~bclk_q;
                if (!bclk_q) begin
                    // Rise edge: bit 0 is the delay bit, bits past DATA_W are padding
                    if (bit_q != '0 && bit_q <= BIT_W'(DATA_W)) begin
                        shift_d = (shift_q << 1) | DATA_W'(DIN);
                    end
                    if (bit_q == BIT_W'(DATA_W)) begin
                        pend_d    = 1'b1;
                        pend_ch_d = ws_q;
                    end
                end else begin
                    // Fall edge: advance bit index, swap slot at its end
                    if (bit_q == BIT_W'(SLOT_W - 1)) begin
                        bit_d = '0;
                        ws_d  = ~ws_q;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
        end
    end

    // FIFO push/pop decisions and sticky overrun
    always_comb begin
        ch_en_c  = pend_ch_q ? (mode != 2'b01) : (mode != 2'b10);
        push_c   = pend_q && ch_en_c;
        pop_c    = valid_q && rd_ready;
        full_c   = (level_q == LW'(FIFO_DEPTH));
        wr_c     = push_c && (!full_c || pop_c);
        wr_ptr_d = wr_c  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(wr_c) - LW'(pop_c);
        valid_d  = (level_d != '0);
        ovr_d    = ovr_q;
        if (push_c && full_c && !pop_c) begin
            ovr_d = 1'b1;
        end else if (clr_overrun) begin
            ovr_d = 1'b0;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bclk_q    <= 1'b0;
            ws_q      <= 1'b0;
            bit_q     <= '0;
            shift_q   <= '0;
            pend_q    <= 1'b0;
            pend_ch_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bclk_q    <= bclk_d;
            ws_q      <= ws_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            pend_q    <= pend_d;
            pend_ch_q <= pend_ch_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    // FIFO storage; cleared on reset so the idle head reads as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                data_mem_q[i] <= '0;
                ch_mem_q[i]   <= 1'b0;
            end
        end else if (wr_c) begin
            data_mem_q[wr_ptr_q] <= shift_q;
            ch_mem_q[wr_ptr_q]   <= pend_ch_q;
        end
    end

    assign BCLK       = bclk_q;
    assign WS         = ws_q;
    assign rd_data    = data_mem_q[rd_ptr_q];
    assign rd_ch      = ch_mem_q[rd_ptr_q];
    assign rd_valid   = valid_q;
    assign fifo_level = level_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// Bench for i2s_rx_fifo: microphone model plus a queue-based FIFO reference.
module tb_i2s_rx_fifo;

    localparam int unsigned DATA_W     = 24;
    localparam int unsigned SLOT_W     = 32;
    localparam int unsigned CLK_DIV    = 3;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned LW         = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic              ch;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [1:0]        mode;
    logic              BCLK;
    logic              WS;
    logic              DIN;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ch;
    logic              rd_valid;
    logic              rd_ready;
    logic [LW-1:0]     fifo_level;
    logic              overrun;
    logic              clr_overrun;

    int nvec = 0;
    int nerr = 0;

    // model / mic state
    ent_t              q[$];
    logic              ovr_m;
    logic [DATA_W-1:0] cur [2];
    logic              rnd;
    int                k;
    int                half;
    logic              bclk_p, ws_p, en_p;
    int                lastfall_cnt = 0;
    int                pop_cnt;
    int                pop_ch1_cnt;
    logic              first_seen;
    logic              first_ch;
    logic [DATA_W-1:0] first_d;

    i2s_rx_fifo #(
        .DATA_W(DATA_W), .SLOT_W(SLOT_W), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .BCLK(BCLK), .WS(WS),
        .DIN(DIN), .rd_data(rd_data), .rd_ch(rd_ch), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .fifo_level(fifo_level), .overrun(overrun),
        .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Mid-cycle monitor: mic driver, timing checks and FIFO reference
    always @(negedge clk) begin
        logic rise, fall, push, pop, ovr_set, ch_on;
        if (!rst_n) begin
            q.delete();
            ovr_m  = 1'b0;
            k      = 0;
            half   = 0;
            bclk_p = 1'b0;
            ws_p   = 1'b0;
            en_p   = 1'b0;
        end else begin
            rise = en_p && !bclk_p && BCLK;
            fall = en_p && bclk_p && !BCLK;

            chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
            chk("fifo_level", 32'(fifo_level), 32'(q.size()));
            chk("overrun", 32'(overrun), 32'(ovr_m));
            if (q.size() != 0) begin
                chk("head_data", 32'(rd_data), 32'(q[0].d));
                chk("head_ch", 32'(rd_ch), 32'(q[0].ch));
            end

            if (!en_p) begin
                chk("idle_bclk_ws", {30'd0, BCLK, WS}, 32'd0);
                half = 0;
            end else begin
                half++;
                if (BCLK != bclk_p) begin
                    chk("bclk_half_period", 32'(half), 32'(CLK_DIV));
                    half = 0;
                end
                if (WS != ws_p) chk("ws_slot_len", 32'((fall ? k : -1)), 32'(SLOT_W - 1));
            end

            push = rise && (k == int'(DATA_W));

            if (!en_p) begin
                k = 0;
                if (rnd) cur[0] = DATA_W'($urandom);
                DIN = 1'($urandom);
            end else if (fall) begin
                if (WS != ws_p) begin
                    k = 0;
                    if (rnd) cur[WS] = DATA_W'($urandom);
                end else begin
                    k++;
                end
                if (k == int'(DATA_W)) lastfall_cnt++;
                if (k >= 1 && k <= int'(DATA_W)) DIN = cur[WS][DATA_W-k];
                else DIN = 1'($urandom);
            end

            pop     = rd_valid && rd_ready;
            ch_on   = WS ? (mode != 2'b01) : (mode != 2'b10);
            ovr_set = 1'b0;
            if (pop && q.size() != 0) begin
                pop_cnt++;
                if (q[0].ch) pop_ch1_cnt++;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_ch   = q[0].ch;
                    first_d    = q[0].d;
                end
                void'(q.pop_front());
            end
            if (push && ch_on) begin
                if (q.size() < int'(FIFO_DEPTH)) q.push_back('{ch: WS, d: cur[WS]});
                else ovr_set = 1'b1;
            end
            if (ovr_set) ovr_m = 1'b1;
            else if (clr_overrun) ovr_m = 1'b0;

            bclk_p = BCLK;
            ws_p   = WS;
            en_p   = en;
        end
    end

    task automatic clr_counts();
        pop_cnt     = 0;
        pop_ch1_cnt = 0;
        first_seen  = 1'b0;
    endtask

    initial begin
        int lf;
        logic got;
        rst_n       = 1'b0;
        en          = 1'b0;
        mode        = 2'b00;
        rd_ready    = 1'b0;
        clr_overrun = 1'b0;
        DIN         = 1'b0;
        rnd         = 1'b0;
        cur[0]      = 24'hABCDEF;
        cur[1]      = 24'h123456;
        clr_counts();
        cycles(3);

        // reset state
        chk("rst_bclk", 32'(BCLK), 32'd0);
        chk("rst_ws", 32'(WS), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_ch", 32'(rd_ch), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        cycles(2);

        // 1: stereo with fixed words, consumer always ready
        rd_ready = 1'b1;
        en = 1'b1;
        cycles(1152);
        en = 1'b0;
        cycles(20);
        chk("t1_pops", 32'(pop_cnt), 32'd6);
        chk("t1_right_pops", 32'(pop_ch1_cnt), 32'd3);
        chk("t1_first_data", 32'(first_d), 32'hABCDEF);
        chk("t1_first_ch", 32'(first_ch), 32'd0);

        // 2: left-only then right-only, random words
        rnd = 1'b1;
        rd_ready = 1'b0;
        clr_counts();
        mode = 2'b01;
        en = 1'b1;
        cycles(1536);
        en = 1'b0;
        cycles(5);
        chk("t2_left_level", 32'(fifo_level), 32'd4);
        rd_ready = 1'b1;
        cycles(12);
        chk("t2_left_pops", 32'(pop_cnt), 32'd4);
        chk("t2_left_ch1", 32'(pop_ch1_cnt), 32'd0);
        rd_ready = 1'b0;
        clr_counts();
        mode = 2'b10;
        en = 1'b1;
        cycles(1536);
        en = 1'b0;
        cycles(5);
        chk("t2_right_level", 32'(fifo_level), 32'd4);
        rd_ready = 1'b1;
        cycles(12);
        chk("t2_right_pops", 32'(pop_cnt), 32'd4);
        chk("t2_right_ch1", 32'(pop_ch1_cnt), 32'd4);

        // 3: overflow with no consumer, then clear overrun and drain
        rd_ready = 1'b0;
        mode = 2'b00;
        clr_counts();
        en = 1'b1;
        cycles(1920);
        en = 1'b0;
        cycles(5);
        chk("t3_level_full", 32'(fifo_level), 32'd8);
        chk("t3_overrun_set", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        cycles(1);
        clr_overrun = 1'b0;
        chk("t3_overrun_clr", 32'(overrun), 32'd0);
        rd_ready = 1'b1;
        cycles(20);
        chk("t3_pops", 32'(pop_cnt), 32'd8);

        // 4: push and pop together while full
        rd_ready = 1'b0;
        en = 1'b1;
        cycles(1536);
        chk("t4_level_full", 32'(fifo_level), 32'd8);
        lf = lastfall_cnt;
        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            cycles(1);
            if (lastfall_cnt != lf) begin
                got = 1'b1;
                break;
            end
        end
        chk("t4_wait_word", 32'(got), 32'd1);
        cycles(CLK_DIV - 1);
        rd_ready = 1'b1;
        cycles(1);
        rd_ready = 1'b0;
        chk("t4_level_kept", 32'(fifo_level), 32'd8);
        chk("t4_no_overrun", 32'(overrun), 32'd0);
        en = 1'b0;
        clr_counts();
        rd_ready = 1'b1;
        cycles(20);
        chk("t4_pops", 32'(pop_cnt), 32'd8);

        // 5: drop enable mid-word, then restart
        clr_counts();
        en = 1'b1;
        cycles(65);
        en = 1'b0;
        cycles(50);
        chk("t5_no_partial", 32'(pop_cnt), 32'd0);
        chk("t5_level", 32'(fifo_level), 32'd0);
        en = 1'b1;
        cycles(384);
        en = 1'b0;
        cycles(10);
        chk("t5_pops", 32'(pop_cnt), 32'd2);
        chk("t5_first_ch", 32'(first_ch), 32'd0);

        // 6: asynchronous reset with entries queued
        rd_ready = 1'b0;
        en = 1'b1;
        cycles(600);
        chk("t6_level", 32'(fifo_level), 32'd3);
        for (int i = 0; i < 20; i++) begin
            if (BCLK) break;
            cycles(1);
        end
        chk("t6_bclk_high", 32'(BCLK), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(rd_valid), 32'd0);
        chk("t6_level0", 32'(fifo_level), 32'd0);
        chk("t6_overrun", 32'(overrun), 32'd0);
        chk("t6_bclk", 32'(BCLK), 32'd0);
        en = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
